fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST  input  1  synchronous active-high reset.
REQ-004 PCWre  input  1  from control unit; 1 = PC may advance, 0 = halt request.
REQ-005 PCSrc  input  2  from control unit; next-PC select.
REQ-006 ext_imm  input  32  sign/zero-extended immediate, branch offset in words.
REQ-007 j_addr  input  26  jump target field, ins[25:0].
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  32  instruction memory byte address, equal to pc.
REQ-010 imem_ready  input  1  memory handshake; imem_rdata valid when high.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 ins  output  32  latched instruction.
REQ-013 op  output  6  ins[31:26], to control unit.
REQ-014 ins_valid  output  1  ins held stable for execute this cycle.
REQ-015 pc  output  32  current PC; pc4 output 32 = pc+4.
REQ-016 halted  output  1  block is in HALT.
REQ-017 retired_cnt  output  32  retired-instruction count (see Configuration).

Function
REQ-018 The FSM SHALL have exactly three states: FETCH, EXEC, HALT.
REQ-019 FETCH: imem_req=1, imem_addr=pc; on imem_ready=1, latch imem_rdata into ins and go to EXEC at the next edge; otherwise stay in FETCH.
REQ-020 EXEC: ins_valid=1, imem_req=0, for exactly one cycle.
REQ-021 At the end of EXEC with PCWre=1, pc SHALL update per PCSrc and the state SHALL return to FETCH.
REQ-022 PCSrc=00 -> pc+4.
REQ-023 PCSrc=01 -> pc+4+(ext_imm<<2).
REQ-024 PCSrc=10 -> {pc4[31:28], j_addr, 2'b00}.
REQ-025 PCSrc=11 -> pc unchanged (re-fetch the same address).
REQ-026 At the end of EXEC with PCWre=0, pc SHALL hold and the state SHALL go to HALT.
REQ-027 HALT: imem_req=0, ins_valid=0, halted=1; ins and pc hold; the only exit is RST.
REQ-028 Minimum throughput: 2 cycles per instruction (FETCH with imem_ready=1, then EXEC); each wait cycle adds 1.
REQ-029 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 = 0x00000000); pc[1:0] SHALL always be 00.
REQ-030 imem_ready SHALL be ignored outside FETCH.
REQ-031 PCWre and PCSrc SHALL be sampled only in EXEC.
REQ-032 op SHALL always equal ins[31:26].

Reset
REQ-033 With RST=1 at an edge: pc=0, ins=0 (op=0), state=FETCH, halted=0, retired_cnt=0; ins_valid=0 and imem_req=1 in the first cycle after release.
REQ-034 RST SHALL take priority in any state, including mid-FETCH with a pending imem_ready, in EXEC, and in HALT.
REQ-035 A pending fetch interrupted by reset SHALL be discarded, and ins SHALL NOT update.

Configuration
REQ-036 Macro FETCH_RETIRE_CNT_EN: when defined, retired_cnt SHALL increment by 1 (wrapping at 2^32) at the end of each EXEC cycle, including the EXEC that enters HALT.
REQ-037 When FETCH_RETIRE_CNT_EN is not defined, retired_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-038 Reset, then imem_ready=1 always, PCSrc=00, PCWre=1 -> imem_addr sequence 0,4,8, each held 2 cycles; ins_valid pulses every 2nd cycle.
REQ-039 At pc=0x10, imem_ready held low 3 cycles -> FETCH lasts 4 cycles with imem_addr=0x10 stable; ins latched only on the ready cycle.
REQ-040 At pc=0x20, PCSrc=01, ext_imm=0xFFFFFFFE -> next pc=0x1C; at pc=0x40000010, PCSrc=10, j_addr=0x0000010 -> next pc=0x40000040.
REQ-041 EXEC with PCWre=0 at pc=0x30 -> halted=1, imem_req=0, pc stays 0x30 for 10+ cycles; RST pulse -> pc=0, FETCH resumes.
REQ-042 RST asserted in FETCH with imem_ready=1, imem_rdata=0xFFFFFFFF -> ins=0, pc=0, state FETCH.
REQ-043 With FETCH_RETIRE_CNT_EN, 5 instructions then halt -> retired_cnt=6; without the macro -> retired_cnt=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch: FETCH/EXEC/HALT sequencer, PC select, optional retired count (FETCH_RETIRE_CNT_EN).
// Latency: 2 cycles/instr minimum; imem_ready low stretches FETCH one cycle per wait, PCWre=0 halts until RST.
module fetch_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] ext_imm,
    input  logic [25:0] j_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic [5:0]  op,
    output logic        ins_valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        halted,
    output logic [31:0] retired_cnt
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] pcNext;
    logic [31:0] branchOffset;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:   nextState = imem_ready ? EXEC : FETCH;
            EXEC:    nextState = PCWre ? FETCH : HALT;
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        ins_valid = 1'b0;
        halted    = 1'b0;
        case (state)
            FETCH:   imem_req  = 1'b1;
            EXEC:    ins_valid = 1'b1;
            HALT:    halted    = 1'b1;
            default: imem_req  = 1'b0;
        endcase
    end

    // Every target is word aligned by construction, so pc[1:0] stays 00 from reset onward.
    assign pc4          = pc + 32'd4;
    assign branchOffset = ext_imm << 2;

    always_comb begin
        pcNext = pc;
        case (PCSrc)
            2'b00:   pcNext = pc4;
            2'b01:   pcNext = pc4 + branchOffset;
            2'b10:   pcNext = {pc4[31:28], j_addr, 2'b00};
            default: pcNext = pc;
        endcase
    end

    // A fetch overlapped by reset is dropped: RST wins over the imem_ready capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc  <= 32'd0;
            ins <= 32'd0;
        end else begin
            if (state == FETCH && imem_ready) begin
                ins <= imem_rdata;
            end
            if (state == EXEC && PCWre) begin
                pc <= pcNext;
            end
        end
    end

    assign imem_addr = pc;
    assign op        = ins[31:26];

`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retiredReg;

    always_ff @(posedge CLK) begin
        if (RST) begin
            retiredReg <= 32'd0;
        end else if (state == EXEC) begin
            retiredReg <= retiredReg + 32'd1;
        end
    end

    assign retired_cnt = retiredReg;
`else
    assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: fetched words queued on the ready cycle, popped when ins_valid shows.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PCWre;
    logic [1:0]  PCSrc;
    logic [31:0] ext_imm;
    logic [25:0] j_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic [5:0]  op;
    logic        ins_valid;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        halted;
    logic [31:0] retired_cnt;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] expPc;
    logic [31:0] lastIns;
    logic [31:0] expRetired;
    logic [31:0] insQ[$];

    fetch_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .PCWre      (PCWre),
        .PCSrc      (PCSrc),
        .ext_imm    (ext_imm),
        .j_addr     (j_addr),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .ins        (ins),
        .op         (op),
        .ins_valid  (ins_valid),
        .pc         (pc),
        .pc4        (pc4),
        .halted     (halted),
        .retired_cnt(retired_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] refNextPc(input logic [31:0] p, input logic [1:0] s,
                                              input logic [31:0] imm, input logic [25:0] ja);
        logic [31:0] p4;
        p4 = p + 32'd4;
        case (s)
            2'b00:   return p4;
            2'b01:   return p4 + (imm << 2);
            2'b10:   return {p4[31:28], ja, 2'b00};
            default: return p;
        endcase
    endfunction

    task automatic countRetire;
`ifdef FETCH_RETIRE_CNT_EN
        expRetired = expRetired + 32'd1;
`endif
    endtask

    // One instruction: 'waits' stalled FETCH cycles, the ready cycle, then EXEC with the given controls.
    task automatic doInstr(input logic [1:0] src, input logic [31:0] imm, input logic [25:0] ja,
                           input logic we, input int waits);
        logic [31:0] w;
        logic [31:0] exp;
        for (int i = 0; i < waits; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            PCWre      = 1'b0;
            PCSrc      = 2'($urandom);
            chk("wait_req", {31'b0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, expPc);
            chk("wait_vld", {31'b0, ins_valid}, 32'd0);
            chk("wait_ins_hold", ins, lastIns);
            step;
        end
        w          = $urandom | 32'h0000_0001;
        imem_ready = 1'b1;
        imem_rdata = w;
        PCWre      = 1'b0;
        PCSrc      = 2'($urandom);
        chk("fetch_req", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, expPc);
        chk("fetch_vld", {31'b0, ins_valid}, 32'd0);
        chk("fetch_halted", {31'b0, halted}, 32'd0);
        insQ.push_back(w);
        step;
        imem_ready = 1'($urandom);
        imem_rdata = $urandom;
        PCWre      = we;
        PCSrc      = src;
        ext_imm    = imm;
        j_addr     = ja;
        chk("exec_vld", {31'b0, ins_valid}, 32'd1);
        chk("exec_req", {31'b0, imem_req}, 32'd0);
        chk("exec_pc", pc, expPc);
        chk("exec_pc4", pc4, expPc + 32'd4);
        chk("exec_retired", retired_cnt, expRetired);
        if (ins_valid && insQ.size() > 0) begin
            exp = insQ.pop_front();
            chk("exec_ins", ins, exp);
            chk("exec_op", {26'b0, op}, {26'b0, exp[31:26]});
            lastIns = exp;
        end
        step;
        countRetire();
        if (we) begin
            expPc = refNextPc(expPc, src, imm, ja);
        end else begin
            chk("halt_flag", {31'b0, halted}, 32'd1);
            chk("halt_req", {31'b0, imem_req}, 32'd0);
            chk("halt_pc", pc, expPc);
        end
    endtask

    initial begin
        RST        = 1'b1;
        PCWre      = 1'b1;
        PCSrc      = 2'b00;
        ext_imm    = 32'd0;
        j_addr     = 26'd0;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        expPc      = 32'd0;
        lastIns    = 32'd0;
        expRetired = 32'd0;
        step;
        step;
        chk("rst_pc", pc, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_op", {26'b0, op}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        RST = 1'b0;
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_vld", {31'b0, ins_valid}, 32'd0);

        // Sequential stream 0,4,8 then 0xC -> 0x10.
        for (int k = 0; k < 4; k++) doInstr(2'b00, 32'd0, 26'd0, 1'b1, 0);
        chk("seq_addr", imem_addr, 32'h10);
        // Three wait cycles at 0x10, then jump to 0x20.
        doInstr(2'b10, 32'd0, 26'd8, 1'b1, 3);
        chk("jmp_20", imem_addr, 32'h20);
        doInstr(2'b01, 32'hFFFF_FFFE, 26'd0, 1'b1, 0);
        chk("br_back_1c", imem_addr, 32'h1C);
        doInstr(2'b01, 32'h0FFF_FFFC, 26'd0, 1'b1, 1);
        chk("br_4000_0010", imem_addr, 32'h4000_0010);
        doInstr(2'b10, 32'd0, 26'h000_0010, 1'b1, 0);
        chk("jmp_4000_0040", imem_addr, 32'h4000_0040);
        doInstr(2'b11, 32'h1234_5678, 26'h3FF_FFFF, 1'b1, 0);
        chk("refetch_same", imem_addr, 32'h4000_0040);
        doInstr(2'b01, 32'h2FFF_FFEE, 26'd0, 1'b1, 2);
        chk("br_top", imem_addr, 32'hFFFF_FFFC);
        doInstr(2'b00, 32'd0, 26'd0, 1'b1, 0);
        chk("pc_wrap", imem_addr, 32'h0);

        // Reset lands on a ready FETCH cycle: the word must be dropped.
        RST        = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hFFFF_FFFF;
        step;
        chk("rstf_ins", ins, 32'd0);
        chk("rstf_pc", pc, 32'd0);
        chk("rstf_req", {31'b0, imem_req}, 32'd1);
        chk("rstf_vld", {31'b0, ins_valid}, 32'd0);
        RST        = 1'b0;
        imem_ready = 1'b0;
        step;
        chk("rstf_stay", {31'b0, imem_req}, 32'd1);
        chk("rstf_ins_hold", ins, 32'd0);
        lastIns    = 32'd0;
        expPc      = 32'd0;
        expRetired = 32'd0;

        // Five retiring instructions landing at 0x30, then a halting one.
        for (int k = 0; k < 4; k++) doInstr(2'b00, 32'd0, 26'd0, 1'b1, k % 2);
        doInstr(2'b10, 32'd0, 26'd12, 1'b1, 0);
        chk("pre_halt_pc", imem_addr, 32'h30);
        doInstr(2'b00, 32'd0, 26'd0, 1'b0, 0);
        for (int k = 0; k < 12; k++) begin
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            PCWre      = 1'b1;
            PCSrc      = 2'($urandom);
            step;
            chk("halt_stay", {31'b0, halted}, 32'd1);
            chk("halt_noreq", {31'b0, imem_req}, 32'd0);
            chk("halt_novld", {31'b0, ins_valid}, 32'd0);
            chk("halt_pc_hold", pc, 32'h30);
            chk("halt_ins_hold", ins, lastIns);
        end
        chk("halt_retired", retired_cnt, expRetired);
`ifdef FETCH_RETIRE_CNT_EN
        chk("retired_six", retired_cnt, 32'd6);
`else
        chk("retired_zero", retired_cnt, 32'd0);
`endif

        RST = 1'b1;
        step;
        RST = 1'b0;
        chk("hrst_pc", pc, 32'd0);
        chk("hrst_halted", {31'b0, halted}, 32'd0);
        chk("hrst_req", {31'b0, imem_req}, 32'd1);
        chk("hrst_retired", retired_cnt, 32'd0);
        lastIns    = 32'd0;
        expPc      = 32'd0;
        expRetired = 32'd0;
        doInstr(2'b00, 32'd0, 26'd0, 1'b1, 1);
        chk("resume_addr", imem_addr, 32'h4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sequence did not complete, %0d/%0d so far", nPass, nChecks);
        $fatal(1, "watchdog expired");
    end

endmodule
